// File: rtl/qbert_jump_sequencer.sv
// Frame-synchronous Qbert jump animator: linear X, parabolic Y arc from xy0 to xy1
// over 2^FRAME_SHIFT frames, with position updates landing during vertical blanking.
module qbert_jump_sequencer #(
  parameter int FRAME_SHIFT = 4,
  parameter int ARC_HEIGHT  = 40
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic                 iNewFrame,
  input  logic                 iEndFrame,
  input  logic                 iStart,
  input  logic [10:0]          iX0,
  input  logic [9:0]           iY0,
  input  logic [10:0]          iX1,
  input  logic [9:0]           iY1,
  output logic [10:0]          oX,
  output logic [9:0]           oY,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [FRAME_SHIFT:0] oStep
);

  // state | meaning
  // IDLE  | outputs track iX0/iY0, waiting for an iStart rising edge
  // ARMED | endpoints latched, waiting for the next frame start
  // JUMP  | frame index advances on iEndFrame, position follows 2 cycles later
  // LAND  | one cycle at (X1,Y1) with oDone high

  localparam int KW  = FRAME_SHIFT + 1;
  localparam int PXW = 13 + KW;
  localparam int PYW = 12 + KW;
  localparam int AW  = 2 * FRAME_SHIFT + 12;
  localparam logic [KW-1:0] N_FRAMES = {1'b1, {FRAME_SHIFT{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_JUMP, S_LAND} state_t;

  state_t             state, state_nxt;
  logic               start_q, start_rise, latch;
  logic [10:0]        x0_l, x1_l, x_nxt, x_pipe;
  logic [9:0]         y0_l, y1_l, y_nxt, y_pipe;
  logic [KW-1:0]      k_cnt, k_nxt, step_q, step_nxt;
  logic signed [11:0] dx;
  logic signed [10:0] dy;
  logic signed [KW:0] k_s;
  logic signed [12:0] off_x, off_x_d;
  logic signed [11:0] off_y, off_y_d;
  logic [9:0]         arc_q, arc_d;
  logic signed [12:0] y_s;

  assign start_rise = iStart & ~start_q;
  assign oBusy      = (state != S_IDLE);
  assign oDone      = (state == S_LAND);

  // Stage 1: offsets and arc height for the current frame index
  assign dx      = $signed({1'b0, x1_l}) - $signed({1'b0, x0_l});
  assign dy      = $signed({1'b0, y1_l}) - $signed({1'b0, y0_l});
  assign k_s     = $signed({1'b0, k_cnt});
  assign off_x_d = 13'((PXW'(dx) * PXW'(k_s)) >>> FRAME_SHIFT);
  assign off_y_d = 12'((PYW'(dy) * PYW'(k_s)) >>> FRAME_SHIFT);
  assign arc_d   = 10'((AW'(4 * ARC_HEIGHT) * AW'(k_cnt) * AW'(N_FRAMES - k_cnt))
                       >> (2 * FRAME_SHIFT));

  // Stage 2: absolute position; Y clamps at the top edge, X never leaves its span
  assign x_pipe = 11'($signed({2'b0, x0_l}) + off_x);
  assign y_s    = $signed({3'b0, y0_l}) + $signed({off_y[11], off_y})
                  - $signed({3'b0, arc_q});
  assign y_pipe = (y_s < 0) ? 10'd0 : 10'(y_s);

  always_comb begin
    state_nxt = state;
    k_nxt     = k_cnt;
    x_nxt     = oX;
    y_nxt     = oY;
    step_nxt  = oStep;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        x_nxt    = iX0;
        y_nxt    = iY0;
        step_nxt = '0;
        k_nxt    = '0;
        if (start_rise) begin
          latch     = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (iNewFrame) begin
          k_nxt     = '0;
          state_nxt = S_JUMP;
        end
      end
      S_JUMP: begin
        if (iEndFrame && (k_cnt != N_FRAMES)) k_nxt = k_cnt + KW'(1);
        x_nxt    = x_pipe;
        y_nxt    = y_pipe;
        step_nxt = step_q;
        if (step_q == N_FRAMES) state_nxt = S_LAND;
      end
      S_LAND: begin
        x_nxt     = iX0;
        y_nxt     = iY0;
        step_nxt  = '0;
        k_nxt     = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state   <= S_IDLE;
      start_q <= 1'b1;
      k_cnt   <= '0;
      oX      <= '0;
      oY      <= '0;
      oStep   <= '0;
      x0_l    <= '0;
      y0_l    <= '0;
      x1_l    <= '0;
      y1_l    <= '0;
      off_x   <= '0;
      off_y   <= '0;
      arc_q   <= '0;
      step_q  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= iStart;
      k_cnt   <= k_nxt;
      oX      <= x_nxt;
      oY      <= y_nxt;
      oStep   <= step_nxt;
      if (latch) begin
        x0_l <= iX0;
        y0_l <= iY0;
        x1_l <= iX1;
        y1_l <= iY1;
      end
      off_x  <= off_x_d;
      off_y  <= off_y_d;
      arc_q  <= arc_d;
      step_q <= k_cnt;
    end
  end

endmodule

// File: tb/tb_qbert_jump_sequencer.sv
// Bench for qbert_jump_sequencer: table of known jump points, randomized jumps against
// an integer reference of the path equations, plus retrigger and mid-jump reset sequences.
module tb_qbert_jump_sequencer;

  localparam int FS = 4;
  localparam int AH = 40;
  localparam int NF = 1 << FS;

  logic        iCLK, iRST_n, iNewFrame, iEndFrame, iStart;
  logic [10:0] iX0, iX1, oX;
  logic [9:0]  iY0, iY1, oY;
  logic        oBusy, oDone;
  logic [FS:0] oStep;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  qbert_jump_sequencer #(.FRAME_SHIFT(FS), .ARC_HEIGHT(AH)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iNewFrame(iNewFrame), .iEndFrame(iEndFrame),
    .iStart(iStart), .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1),
    .oX(oX), .oY(oY), .oBusy(oBusy), .oDone(oDone), .oStep(oStep)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) if (oDone) done_cnt++;

  typedef struct {
    int x0, y0, x1, y1, k, ex, ey;
  } vec_t;
  vec_t tab[7];

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_x(input int x0, input int x1, input int k);
    return x0 + floor_div((x1 - x0) * k, NF);
  endfunction

  function automatic int model_y(input int y0, input int y1, input int k);
    int y;
    y = y0 + floor_div((y1 - y0) * k, NF) - (4 * AH * k * (NF - k)) / (NF * NF);
    return (y < 0) ? 0 : y;
  endfunction

  task automatic run_jump(input int x0, input int y0, input int x1, input int y1,
                          input int chk_k, input int ex, input int ey,
                          input int disturb_k, input int abort_k);
    int done0, lo, hi;
    lo = (x0 < x1) ? x0 : x1;
    hi = (x0 < x1) ? x1 : x0;
    iX0 = 11'(x0); iY0 = 10'(y0); iX1 = 11'(x1); iY1 = 10'(y1);
    iStart = 1'b0;
    tick();
    iStart = 1'b1;
    tick();
    check("busy_on_trigger", oBusy, 1);
    iEndFrame = 1'b1;
    tick();
    iEndFrame = 1'b0;
    tick();
    tick();
    check("armed_step", oStep, 0);
    check("armed_x", oX, x0);
    done0 = done_cnt;
    iNewFrame = 1'b1;
    tick();
    iNewFrame = 1'b0;
    tick();
    tick();
    for (int k = 1; k <= NF; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      iEndFrame = 1'b1;
      tick();
      iEndFrame = 1'b0;
      tick();
      check("latency_early_step", oStep, k - 1);
      tick();
      check("step", oStep, k);
      check("model_x", oX, model_x(x0, x1, k));
      check("model_y", oY, model_y(y0, y1, k));
      check("x_in_span", int'((oX >= lo) && (oX <= hi)), 1);
      if (k == chk_k) begin
        check("table_x", oX, ex);
        check("table_y", oY, ey);
      end
      check("done_pulse", oDone, (k == NF) ? 1 : 0);
      check("busy_during", oBusy, 1);
      if (k == abort_k) begin
        iRST_n = 1'b0;
        tick();
        check("abort_busy", oBusy, 0);
        check("abort_step", oStep, 0);
        check("abort_done", oDone, 0);
        check("abort_x", oX, 0);
        check("abort_y", oY, 0);
        iRST_n = 1'b1;
        tick();
        check("abort_no_done", done_cnt - done0, 0);
        return;
      end
      if (k == disturb_k) begin
        iStart = 1'b0;
        tick();
        iStart = 1'b1;
        iX1 = 11'd500;
        iY1 = 10'd3;
        tick();
        check("retrigger_ignored", oStep, k);
      end
    end
    tick();
    check("land_busy_off", oBusy, 0);
    check("land_done_off", oDone, 0);
    check("land_track_x0", oX, int'(iX0));
    check("land_track_y0", oY, int'(iY0));
    check("one_done", done_cnt - done0, 1);
  endtask

  initial begin
    tab[0] = '{100, 200, 164, 232,  4, 116, 178};
    tab[1] = '{100, 200, 164, 232,  8, 132, 176};
    tab[2] = '{100, 200, 164, 232, 16, 164, 232};
    tab[3] = '{300, 100, 236, 100,  8, 268,  60};
    tab[4] = '{300, 100, 236, 100, 16, 236, 100};
    tab[5] = '{ 50,  10,  50,  10,  8,  50,   0};
    tab[6] = '{ 50,  10,  50,  10, 16,  50,  10};

    iRST_n = 1'b0; iStart = 1'b1; iNewFrame = 1'b0; iEndFrame = 1'b0;
    iX0 = 11'd100; iY0 = 10'd200; iX1 = 11'd0; iY1 = 10'd0;
    repeat (3) tick();
    check("rst_x", oX, 0);
    check("rst_y", oY, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_step", oStep, 0);
    iRST_n = 1'b1;
    tick();
    check("idle_track_x", oX, 100);
    check("idle_track_y", oY, 200);
    iNewFrame = 1'b1;
    tick();
    iNewFrame = 1'b0;
    iEndFrame = 1'b1;
    tick();
    iEndFrame = 1'b0;
    repeat (3) tick();
    check("held_start_no_jump", oBusy, 0);
    check("idle_step", oStep, 0);

    foreach (tab[i])
      run_jump(tab[i].x0, tab[i].y0, tab[i].x1, tab[i].y1, tab[i].k, tab[i].ex, tab[i].ey, -1, -1);

    run_jump(100, 200, 164, 232, 16, 164, 232, 5, -1);
    run_jump(100, 200, 164, 232, -1, 0, 0, -1, 7);
    run_jump(100, 200, 164, 232, 16, 164, 232, -1, -1);

    for (int r = 0; r < 6; r++)
      run_jump(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), -1, 0, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
